time_keeper_ctrl: RTL and testbench
===================================

# time_keeper_ctrl

Sequencing controller for the VGA clock's time registers. It owns the BCD hours/minutes/seconds state and arbitrates updates to it from three sources: the 1 Hz timebase, the three debounced adjust buttons, and an optional external load port driven from Caravel logic. It serialises minute and hour carries one field per cycle. It sits between the input conditioning and the digit-rendering datapath, which only reads its outputs.

## Interface
- TICK_DIV, 31_500_000: clk cycles per second; legal range ≥ 2.
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- adj_hrs  in  1  one-cycle pulse: increment hours, no carry.
- adj_min  in  1  one-cycle pulse: increment minutes, no carry.
- adj_sec  in  1  one-cycle pulse: increment seconds, no carry.
- load_valid  in  1  load request.
- load_data  in  24  BCD {hr_t, hr_u, min_t, min_u, sec_t, sec_u}, 4 bits each, MSB first.
- load_ready  out  1  load accepted on an edge where valid and ready are both high.
- load_err  out  1  one-cycle pulse: accepted load was out of range.
- hrs  out  8  BCD hours, 00–23.
- mins  out  8  BCD minutes, 00–59.
- secs  out  8  BCD seconds, 00–59.
- sec_tick  out  1  one-cycle pulse in the first cycle a tick-driven seconds value is visible.

## Operation
- **Reset values:** hrs/mins/secs = 00, state IDLE, all pending bits 0, prescaler 0, sec_tick 0, load_err 0.
- **Prescaler:** counts 0..TICK_DIV-1 and wraps. On wrap it sets `tick_pend`.
- **Pending bits:** `tick_pend`, `sec_pend`, `min_pend`, `hrs_pend`.
  - A request sets its bit; a grant clears it.
  - If set and clear happen on the same edge, set wins.
  - Repeated pulses while a bit is pending merge into one update.
- **FSM states:** IDLE, CARRY_MIN, CARRY_HR.
- **Arbitration:** grants happen only in IDLE, at most one per cycle, in fixed priority load > tick > sec > min > hrs.
- **Load grant:** the grant is the handshake itself. load_ready = (state == IDLE).
  - Valid data: all fields are written on the accept edge, the prescaler is cleared, and all pending bits are cleared.
  - Invalid data (any unit > 9, sec_t or min_t > 5, hours > 23): fields are unchanged, load_err pulses on the next cycle, pending bits are kept.
- **Tick grant:** secs+1.
  - If secs was 59: secs = 00, go to CARRY_MIN.
  - CARRY_MIN: mins+1. If mins was 59: mins = 00, go to CARRY_HR; otherwise go to IDLE.
  - CARRY_HR: hrs = (hrs == 23) ? 00 : hrs+1, go to IDLE.
- **Adjust grants:** the field wraps (59→00, or 23→00 for hours) with no carry, and state stays IDLE.
- **BCD arithmetic:** a unit digit of 9 rolls to 0 and increments the tens digit. Outputs never hold a non-BCD digit.
- **Mid-operation reset:** reset_n low in any state returns everything to reset values immediately.

## Timing
- A request pulse sampled at edge E sets its pending bit at E. The field updates at E+1 if the FSM is IDLE and no higher-priority request is present.
- A load accepted at edge E updates the fields at E, so the new value is visible in the cycle after E.
- Worst-case tick carry (23:59:59 → 00:00:00): 3 consecutive update edges. load_ready is low for the 2 carry cycles.
- sec_tick is high in the same cycle as the updated secs value. It is not asserted for adjust or load updates.
- A request blocked by a carry or a higher-priority grant waits in its pending bit and is never lost.

## Configuration
- **TIME_LOAD_EN defined:** the load port is functional as described above.
- **TIME_LOAD_EN undefined:**
  - load_ready and load_err are tied to 0.
  - load_valid and load_data are ignored.
  - Ports are kept so the wrapper netlist is unchanged.
  - The arbiter reduces to tick > sec > min > hrs.

## Test plan
- **Reset:** assert reset_n = 0 mid-carry → next cycle shows hrs/mins/secs = 00/00/00, load_ready = 1, sec_tick = 0, load_err = 0.
- **Prescaler:** TICK_DIV = 4 → secs steps 00, 01, 02 every 4 cycles, with sec_tick high for exactly 1 cycle each time.
- **Full carry:** load 0x235959, then wait for a tick → secs 00, then mins 00, then hrs 00 on 3 consecutive edges; load_ready = 0 for 2 cycles.
- **Adjust wrap:** adj_sec at 12:34:59 → 12:34:00 with mins unchanged; adj_hrs at 23:00:00 → 00:00:00; two adj_min pulses 1 cycle apart while blocked → a single increment.
- **Simultaneous requests:** tick and adj_min on the same edge from 00:10:05 → 00:10:06 first, then 00:11:06 one cycle later.
- **Invalid load:** load 0x246000 → load_err pulses once and the time is unchanged. Build without TIME_LOAD_EN → load_ready stays 0 and load_valid has no effect.

Source files
------------

// File: rtl/time_keeper_ctrl.sv
// rtl/time_keeper_ctrl.sv - BCD time-of-day sequencer arbitrating 1 Hz tick, adjust buttons and load port
// Load port is functional only when TIME_LOAD_EN is defined.
module time_keeper_ctrl #(
    parameter int TICK_DIV = 31_500_000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_adj_hrs,
    input  logic        i_adj_min,
    input  logic        i_adj_sec,
    input  logic        i_load_valid,
    input  logic [23:0] i_load_data,
    output logic        o_load_ready,
    output logic        o_load_err,
    output logic [7:0]  o_hrs,
    output logic [7:0]  o_mins,
    output logic [7:0]  o_secs,
    output logic        o_sec_tick
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CARRY_MIN, S_CARRY_HR} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_hrs, r_mins, r_secs;
    logic [7:0]    w_hrs_nxt, w_mins_nxt, w_secs_nxt;
    logic [PW-1:0] r_presc;
    logic          r_tick_pend, r_sec_pend, r_min_pend, r_hrs_pend;
    logic          r_sec_tick, r_load_err;
    logic          w_wrap, w_idle, w_load_acc, w_load_ok;
    logic          w_gnt_tick, w_gnt_sec, w_gnt_min, w_gnt_hrs;
    logic          w_clr_all, w_tick_evt, w_err_evt;

    // Top value wraps to 00; otherwise a units digit of 9 rolls into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_wrap = (r_presc == PRESC_MAX);
    assign w_idle = (r_state == S_IDLE);

    assign w_load_ok = (i_load_data[3:0]   <= 4'd9) && (i_load_data[7:4]   <= 4'd5) &&
                       (i_load_data[11:8]  <= 4'd9) && (i_load_data[15:12] <= 4'd5) &&
                       (((i_load_data[23:20] <  4'd2) && (i_load_data[19:16] <= 4'd9)) ||
                        ((i_load_data[23:20] == 4'd2) && (i_load_data[19:16] <= 4'd3)));

`ifdef TIME_LOAD_EN
    assign w_load_acc   = i_load_valid & w_idle;
    assign o_load_ready = w_idle;
`else
    logic w_unused_load;
    assign w_unused_load = i_load_valid;
    assign w_load_acc    = 1'b0;
    assign o_load_ready  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_hrs_nxt   = r_hrs;
        w_mins_nxt  = r_mins;
        w_secs_nxt  = r_secs;
        w_gnt_tick  = 1'b0;
        w_gnt_sec   = 1'b0;
        w_gnt_min   = 1'b0;
        w_gnt_hrs   = 1'b0;
        w_clr_all   = 1'b0;
        w_tick_evt  = 1'b0;
        w_err_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load_acc) begin
                    if (w_load_ok) begin
                        w_hrs_nxt  = i_load_data[23:16];
                        w_mins_nxt = i_load_data[15:8];
                        w_secs_nxt = i_load_data[7:0];
                        w_clr_all  = 1'b1;
                    end else begin
                        w_err_evt = 1'b1;
                    end
                end else if (r_tick_pend) begin
                    w_gnt_tick = 1'b1;
                    w_tick_evt = 1'b1;
                    w_secs_nxt = bcd_inc(r_secs, 8'h59);
                    if (r_secs == 8'h59)
                        w_state_nxt = S_CARRY_MIN;
                end else if (r_sec_pend) begin
                    w_gnt_sec  = 1'b1;
                    w_secs_nxt = bcd_inc(r_secs, 8'h59);
                end else if (r_min_pend) begin
                    w_gnt_min  = 1'b1;
                    w_mins_nxt = bcd_inc(r_mins, 8'h59);
                end else if (r_hrs_pend) begin
                    w_gnt_hrs  = 1'b1;
                    w_hrs_nxt  = bcd_inc(r_hrs, 8'h23);
                end
            end
            S_CARRY_MIN: begin
                w_mins_nxt  = bcd_inc(r_mins, 8'h59);
                w_state_nxt = (r_mins == 8'h59) ? S_CARRY_HR : S_IDLE;
            end
            S_CARRY_HR: begin
                w_hrs_nxt   = bcd_inc(r_hrs, 8'h23);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pending bits: a new request on the same edge as its grant keeps the bit set.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_hrs       <= 8'h00;
            r_mins      <= 8'h00;
            r_secs      <= 8'h00;
            r_presc     <= '0;
            r_tick_pend <= 1'b0;
            r_sec_pend  <= 1'b0;
            r_min_pend  <= 1'b0;
            r_hrs_pend  <= 1'b0;
            r_sec_tick  <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hrs       <= w_hrs_nxt;
            r_mins      <= w_mins_nxt;
            r_secs      <= w_secs_nxt;
            r_presc     <= (w_clr_all || w_wrap) ? '0 : r_presc + PW'(1);
            r_tick_pend <= w_wrap    | (r_tick_pend & ~(w_gnt_tick | w_clr_all));
            r_sec_pend  <= i_adj_sec | (r_sec_pend  & ~(w_gnt_sec  | w_clr_all));
            r_min_pend  <= i_adj_min | (r_min_pend  & ~(w_gnt_min  | w_clr_all));
            r_hrs_pend  <= i_adj_hrs | (r_hrs_pend  & ~(w_gnt_hrs  | w_clr_all));
            r_sec_tick  <= w_tick_evt;
            r_load_err  <= w_err_evt;
        end
    end

    assign o_hrs      = r_hrs;
    assign o_mins     = r_mins;
    assign o_secs     = r_secs;
    assign o_sec_tick = r_sec_tick;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_time_keeper_ctrl.sv
// tb/tb_time_keeper_ctrl.sv - randomized lockstep bench for time_keeper_ctrl against a seconds/minutes/hours model
module tb_time_keeper_ctrl;
    localparam int DIV = 4;
`ifdef TIME_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        adj_hrs = 1'b0, adj_min = 1'b0, adj_sec = 1'b0;
    logic        load_valid = 1'b0;
    logic [23:0] load_data = 24'h0;
    logic        load_ready, load_err, sec_tick;
    logic [7:0]  hrs, mins, secs;

    time_keeper_ctrl #(.TICK_DIV(DIV)) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_adj_hrs(adj_hrs), .i_adj_min(adj_min), .i_adj_sec(adj_sec),
        .i_load_valid(load_valid), .i_load_data(load_data),
        .o_load_ready(load_ready), .o_load_err(load_err),
        .o_hrs(hrs), .o_mins(mins), .o_secs(secs), .o_sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: plain integer time, a carry stage counter (0 idle, 1 minute, 2 hour) and request flags.
    int m_h, m_m, m_s, m_presc, m_stage;
    bit m_tp, m_sp, m_mp, m_hp, m_tick, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_stage = 0;
        m_tp = 0; m_sp = 0; m_mp = 0; m_hp = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_step();
        int d[6];
        bit load_acc, load_ok, clr_all, wrap;
        for (int i = 0; i < 6; i++) d[i] = int'((load_data >> (20 - 4 * i)) & 24'hF);
        load_ok  = d[1] <= 9 && d[3] <= 9 && d[5] <= 9 && d[2] <= 5 && d[4] <= 5 && (d[0] * 10 + d[1]) <= 23;
        load_acc = LOAD_EN && m_stage == 0 && load_valid;
        wrap     = (m_presc == DIV - 1);
        clr_all  = 0; m_tick = 0; m_err = 0;
        if (m_stage == 1) begin
            m_stage = (m_m == 59) ? 2 : 0;
            m_m = (m_m + 1) % 60;
        end else if (m_stage == 2) begin
            m_h = (m_h + 1) % 24; m_stage = 0;
        end else if (load_acc) begin
            if (load_ok) begin
                m_h = d[0] * 10 + d[1]; m_m = d[2] * 10 + d[3]; m_s = d[4] * 10 + d[5];
                clr_all = 1; m_tp = 0; m_sp = 0; m_mp = 0; m_hp = 0;
            end else m_err = 1;
        end else if (m_tp) begin
            m_tp = 0; m_tick = 1;
            if (m_s == 59) m_stage = 1;
            m_s = (m_s + 1) % 60;
        end else if (m_sp) begin m_sp = 0; m_s = (m_s + 1) % 60;
        end else if (m_mp) begin m_mp = 0; m_m = (m_m + 1) % 60;
        end else if (m_hp) begin m_hp = 0; m_h = (m_h + 1) % 24;
        end
        m_presc = (clr_all || wrap) ? 0 : m_presc + 1;
        if (wrap)    m_tp = 1;
        if (adj_sec) m_sp = 1;
        if (adj_min) m_mp = 1;
        if (adj_hrs) m_hp = 1;
    endtask

    task automatic compare_all();
        check("hrs", hrs, to_bcd(m_h));
        check("mins", mins, to_bcd(m_m));
        check("secs", secs, to_bcd(m_s));
        check("sec_tick", sec_tick, m_tick);
        check("load_err", load_err, m_err);
        check("load_ready", load_ready, LOAD_EN && m_stage == 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse(input int which);
        adj_sec = (which == 0); adj_min = (which == 1); adj_hrs = (which == 2);
        cycle();
        adj_sec = 0; adj_min = 0; adj_hrs = 0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, n, rs, rm, h, mm, ss;
        bit reached, did_reset;
        did_reset = 0;
        model_reset();
        repeat (2) cycle();
        check("rst_hrs", hrs, 8'h00);
        check("rst_secs", secs, 8'h00);
        check("rst_tick", sec_tick, 1'b0);
        reset_n = 1;

        // Free-running prescaler: grants at edges 5, 9, ..., 37 after release.
        cnt = 0;
        repeat (40) begin cycle(); if (sec_tick) cnt++; end
        check("tick_count", cnt, 9);
        check("secs_after_40", secs, 8'h09);

`ifndef TIME_LOAD_EN
        load_valid = 1; load_data = 24'h000000;
        repeat (8) begin cycle(); check("noload_ready", load_ready, 1'b0); end
        check("noload_secs", secs, to_bcd(m_s));
        load_valid = 0;
`endif

        // Steer to 23:59:56..58 using only the adjust buttons.
        n = 0;
        reached = 0;
        while (!reached && n < 4000) begin
            if (m_h == 23 && m_m == 59 && m_s >= 56 && m_s <= 58 && m_stage == 0 && !m_sp && !m_mp && !m_hp)
                reached = 1;
            else if (m_h != 23 && !m_hp) pulse(2);
            else if (m_m != 59 && !m_mp) pulse(1);
            else if ((m_s < 56 || m_s == 59) && !m_sp) pulse(0);
            else cycle();
            n++;
        end
        check("steer_reached", reached, 1'b1);

        n = 0;
        while (m_stage != 1 && n < 200) begin cycle(); n++; end
        check("carry_wait", n < 200, 1'b1);
        check("carry0_secs", secs, 8'h00);
        check("carry0_mins", mins, 8'h59);
        check("carry0_hrs", hrs, 8'h23);
        check("carry0_ready", load_ready, 1'b0);
        adj_min = 1;
        cycle();
        check("carry1_mins", mins, 8'h00);
        check("carry1_hrs", hrs, 8'h23);
        check("carry1_ready", load_ready, 1'b0);
        cycle();
        adj_min = 0;
        check("carry2_hrs", hrs, 8'h00);
        check("carry2_ready", load_ready, LOAD_EN);
        cycle();
        check("merge_min", mins, 8'h01);
        repeat (4) cycle();
        check("merge_min_hold", mins, 8'h01);

        // Hours adjust wraps 23 -> 00 without touching minutes.
        n = 0;
        while (m_h != 23 && n < 400) begin if (!m_hp) pulse(2); else cycle(); n++; end
        while ((m_hp || m_stage != 0) && n < 400) begin cycle(); n++; end
        rm = m_m;
        pulse(2);
        repeat (3) cycle();
        check("adj_hrs_wrap", hrs, 8'h00);
        check("adj_hrs_mins", mins, to_bcd(rm));

        // Tick and adj_min requested on the same edge: seconds first, then minutes.
        n = 0;
        while (!(m_presc == DIV - 1 && m_s < 58 && m_m < 59 && m_stage == 0 && !m_tp && !m_sp && !m_mp && !m_hp) && n < 400) begin
            cycle(); n++;
        end
        rs = m_s; rm = m_m;
        adj_min = 1;
        cycle();
        adj_min = 0;
        cycle();
        check("simul_secs", secs, to_bcd(rs + 1));
        check("simul_mins_hold", mins, to_bcd(rm));
        cycle();
        check("simul_mins", mins, to_bcd(rm + 1));

`ifdef TIME_LOAD_EN
        while (m_stage != 0 || m_presc == DIV - 1) cycle();
        rs = m_h;
        load_valid = 1; load_data = 24'h246000;
        cycle();
        load_valid = 0;
        check("bad_load_err", load_err, 1'b1);
        check("bad_load_hrs", hrs, to_bcd(rs));
        cycle();
        check("bad_load_err_end", load_err, 1'b0);

        while (m_stage != 0 || m_presc == DIV - 1) cycle();
        load_valid = 1; load_data = 24'h123459; adj_sec = 1;
        cycle();
        load_valid = 0; adj_sec = 0;
        check("load_val", {hrs, mins, secs}, 24'h123459);
        cycle();
        check("adj_sec_wrap", {hrs, mins, secs}, 24'h123400);

        while (m_stage != 0) cycle();
        load_valid = 1; load_data = 24'h235959;
        cycle();
        load_valid = 0;
        repeat (5) cycle();
        check("ld_carry0", {hrs, mins, secs}, 24'h235900);
        check("ld_carry0_ready", load_ready, 1'b0);
        cycle();
        check("ld_carry1", {hrs, mins, secs}, 24'h230000);
        cycle();
        check("ld_carry2", {hrs, mins, secs}, 24'h000000);
        check("ld_carry2_ready", load_ready, 1'b1);
`endif

        // Random traffic with one asynchronous reset landing mid-carry.
        for (int i = 0; i < 2500; i++) begin
            adj_sec    = ($urandom_range(0, 5) == 0);
            adj_min    = ($urandom_range(0, 5) == 0);
            adj_hrs    = ($urandom_range(0, 5) == 0);
            load_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) begin
                h = $urandom_range(0, 23); mm = $urandom_range(0, 59); ss = $urandom_range(0, 59);
                load_data = {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
            end else begin
                load_data = 24'($urandom());
            end
            cycle();
            if (!did_reset && i > 300 && m_stage != 0) begin
                did_reset = 1;
                #2;
                reset_n = 0;
                #1;
                model_reset();
                check("midrst_time", {hrs, mins, secs}, 24'h000000);
                check("midrst_ready", load_ready, LOAD_EN);
                check("midrst_tick", sec_tick, 1'b0);
                check("midrst_err", load_err, 1'b0);
                cycle();
                reset_n = 1;
            end
        end
        check("midrst_done", did_reset, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
